keycode_fifo_pio: RTL and testbench
===================================

Name: keycode_fifo_pio

Overview:
- Parametrised successor to the single-register keycode PIO: an Avalon-MM slave that software (USB keyboard driver on the soft CPU) writes keycodes into.
- Buffers keycodes in a FIFO and hands them to fabric logic (game/control FSM) over a valid/ready stream, so no key event is lost between frames.
- Keeps a "last keycode" level output for legacy consumers.
- Adds status, overflow detection, flush and an interrupt.

Parameters:
- DATA_W, 32, keycode word width (1..32).
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; combinational, 0 wait states, read latency 0.
- out_port  out  DATA_W  last keycode accepted from the bus.
- key_data  out  DATA_W  FIFO head (show-ahead).
- key_valid  out  1  head valid (FIFO not empty).
- key_ready  in  1  consumer accepts head.
- irq  out  1  interrupt, level.

Behaviour:
- Register map; write = chipselect & ~write_n. All unused read bits are 0.
  - addr 0 DATA. Write pushes writedata[DATA_W-1:0] and updates out_port. Read returns out_port zero-extended.
  - addr 1 STATUS. Read: [0] empty, [1] full, [2] overflow (sticky), [8+CNT_W-1:8] count. Writing 1 to bit 2 clears overflow; other bits are ignored.
  - addr 2 CONTROL. Bits: [0] enable, [1] flush, [2] irq_en. Read returns {irq_en, 0, enable}. Writing 1 to bit 1 flushes; flush is a self-clearing strobe.
  - addr 3 reserved: reads 0, writes ignored.
- Reset values:
  - out_port 0, FIFO empty, count 0.
  - key_valid 0, key_data 0.
  - overflow 0, enable 1, irq_en 0, irq 0.
- Push: DATA write with enable = 1.
  - enable = 0: write updates out_port only; nothing enters the FIFO.
- Pop: key_valid & key_ready.
  - key_data is stable while key_valid & ~key_ready.
- Latency: a push into an empty FIFO gives key_valid = 1 and key_data = the value on the next clk edge.
- Full, push without pop: data dropped, overflow set next cycle, out_port still updated.
- Full, push and pop in the same cycle: both accepted; count unchanged; no overflow.
- Empty, push and pop: the pop is impossible (key_valid = 0); the push proceeds.
- Flush: read/write pointers and count go to 0 next cycle and key_valid drops. A pop asserted in the same cycle is ignored. overflow and out_port are unaffected.
- Pointers are CNT_W-1 bits and wrap modulo DEPTH; count = 0..DEPTH.
- irq = irq_en & overflow, registered.
- Async reset mid-transfer discards FIFO contents; no partial state survives.

Decomposition:
- Package keycode_fifo_pkg holds:
  - address constants ADDR_DATA = 0, ADDR_STATUS = 1, ADDR_CTRL = 2;
  - STATUS/CONTROL bit-index constants.
- Sub-module sync_fifo (DATA_W, DEPTH):
  - inputs push, pop, flush;
  - outputs head, empty, full, count;
  - register-based show-ahead storage.
- The top level holds the Avalon decode, control/status registers, out_port and irq.

Test Plan:
- Reset, then read all four addresses -> DATA 0, STATUS 0x1, CTRL 0x1, addr 3 0; key_valid 0; irq 0.
- Write 0x1C to DATA with key_ready = 0 -> next cycle key_valid 1, key_data 0x1C, out_port 0x1C, STATUS count 1. Pulse key_ready -> key_valid 0, count 0.
- DEPTH = 8, key_ready = 0, write 0x01..0x09 -> STATUS full = 1, overflow = 1, count 8, out_port 0x09. Drain -> 0x01..0x08 in order; 0x09 never appears.
- Fill to 8, then write 0x0A while key_ready = 1 -> overflow stays 0, count 8. Drain yields 0x02..0x08 then 0x0A.
- Overflow set with CTRL irq_en = 1 -> irq 1. Write STATUS bit 2 = 1 -> overflow and irq 0 within 2 cycles.
- Flush and enable:
  - Push 3 entries, then write CTRL 0x3 -> key_valid 0 and count 0 next cycle; out_port keeps the last value.
  - Write CTRL 0x0, then write 0x55 -> out_port 0x55, FIFO stays empty.

Source files
------------

// File: rtl/keycode_fifo_pio_pkg.sv
// Shared register-map constants for the keycode FIFO PIO.
`timescale 1ns/1ps
package keycode_fifo_pkg;
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;
endpackage

// File: rtl/keycode_fifo_pio_sync_fifo.sv
// Register-based show-ahead FIFO with flush; head reads 0 while empty.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic              o_empty,
  output logic              o_full,
  output logic [CNT_W-1:0]  o_count
);
  localparam int PTR_W = CNT_W - 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Flush dominates; a pop frees the slot a same-cycle push into a full FIFO needs.
  assign w_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_push = i_push & ~i_flush & (~o_full | w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/keycode_fifo_pio.sv
// Avalon-MM keycode PIO: FIFO-buffered keycode stream, last-key level output, status and irq.
`timescale 1ns/1ps
module keycode_fifo_pio
  import keycode_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] key_data,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              irq
);
  logic [DATA_W-1:0] r_out_port;
  logic              r_ovf, r_en, r_irq_en, r_irq;
  logic              w_wr, w_data_wr, w_push, w_flush, w_pop, w_ovf_set;
  logic              w_empty, w_full;
  logic [CNT_W-1:0]  w_count;
  logic [31:0]       w_status;

  assign w_wr      = chipselect & ~write_n;
  assign w_data_wr = w_wr & (address == ADDR_DATA);
  assign w_push    = w_data_wr & r_en;
  assign w_flush   = w_wr & (address == ADDR_CTRL) & writedata[CTRL_FLUSH];
  assign w_pop     = key_ready & ~w_empty;
  assign w_ovf_set = w_push & w_full & ~w_pop;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (key_ready),
    .i_flush (w_flush),
    .i_data  (writedata[DATA_W-1:0]),
    .o_head  (key_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_port <= '0;
      r_ovf      <= 1'b0;
      r_en       <= 1'b1;
      r_irq_en   <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_data_wr) r_out_port <= writedata[DATA_W-1:0];
      if (w_ovf_set) r_ovf <= 1'b1;
      else if (w_wr && address == ADDR_STATUS && writedata[ST_OVF]) r_ovf <= 1'b0;
      if (w_wr && address == ADDR_CTRL) begin
        r_en     <= writedata[CTRL_EN];
        r_irq_en <= writedata[CTRL_IRQ_EN];
      end
      r_irq <= r_irq_en & r_ovf;
    end
  end

  always_comb begin
    w_status                        = '0;
    w_status[ST_EMPTY]              = w_empty;
    w_status[ST_FULL]               = w_full;
    w_status[ST_OVF]                = r_ovf;
    w_status[ST_CNT_LSB +: CNT_W]   = w_count;
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = 32'(r_out_port);
      ADDR_STATUS: readdata = w_status;
      ADDR_CTRL:   readdata = {29'd0, r_irq_en, 1'b0, r_en};
      default:     readdata = '0;
    endcase
  end

  assign out_port  = r_out_port;
  assign key_valid = ~w_empty;
  assign irq       = r_irq;
endmodule

// File: tb/tb_keycode_fifo_pio.sv
// Directed bench for keycode_fifo_pio (DATA_W=32, DEPTH=8).
`timescale 1ns/1ps
module tb_keycode_fifo_pio;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_port;
  logic [31:0] key_data;
  logic        key_valid;
  logic        key_ready;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  keycode_fifo_pio #(.DATA_W(32), .DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .key_data(key_data), .key_valid(key_valid),
    .key_ready(key_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  // Sample the head, then hold key_ready for exactly one edge.
  task automatic pop_one(output logic v, output logic [31:0] d);
    @(negedge clk);
    v = key_valid; d = key_data;
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h1; exp_rd[2] = 32'h1; exp_rd[3] = 32'h0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      n_checks++;
      if (rd !== exp_rd[a]) begin
        n_fail++; $display("FAIL reset_read addr%0d: got %h expected %h", a, rd, exp_rd[a]);
      end
    end
    n_checks++;
    if ({key_valid, irq} !== 2'b00) begin
      n_fail++; $display("FAIL reset_outputs: key_valid=%b irq=%b expected 0 0", key_valid, irq);
    end
    n_checks++;
    if (key_data !== 32'h0 || out_port !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: key_data=%h out_port=%h expected 0 0", key_data, out_port);
    end
  endtask

  task automatic test_single;
    logic [31:0] rd;
    logic v; logic [31:0] d;
    bus_write(2'd0, 32'h1C);
    n_checks++;
    if (key_valid !== 1'b1 || key_data !== 32'h1C || out_port !== 32'h1C) begin
      n_fail++; $display("FAIL single_push: valid=%b data=%h out_port=%h expected 1 1c 1c", key_valid, key_data, out_port);
    end
    bus_read(2'd1, rd);
    n_checks++;
    if (rd !== 32'h100) begin
      n_fail++; $display("FAIL single_status: got %h expected 00000100", rd);
    end
    pop_one(v, d);
    bus_read(2'd1, rd);
    n_checks++;
    if (key_valid !== 1'b0 || rd !== 32'h1) begin
      n_fail++; $display("FAIL single_pop: valid=%b status=%h expected 0 00000001", key_valid, rd);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] rd;
    logic v; logic [31:0] d;
    for (int i = 1; i <= 9; i++) bus_write(2'd0, 32'(i));
    bus_read(2'd1, rd);
    n_checks++;
    if (rd !== 32'h806) begin
      n_fail++; $display("FAIL ovf_status: got %h expected 00000806", rd);
    end
    n_checks++;
    if (out_port !== 32'h9) begin
      n_fail++; $display("FAIL ovf_out_port: got %h expected 9", out_port);
    end
    for (int i = 1; i <= 8; i++) begin
      pop_one(v, d);
      n_checks++;
      if (v !== 1'b1 || d !== 32'(i)) begin
        n_fail++; $display("FAIL ovf_drain[%0d]: valid=%b data=%h expected 1 %h", i, v, d, i);
      end
    end
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_drained: key_valid=%b expected 0", key_valid);
    end
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++; $display("FAIL ovf_clear: got %h expected 00000001", rd);
    end
  endtask

  task automatic test_full_pushpop;
    logic [31:0] rd;
    logic v; logic [31:0] d;
    logic [31:0] exp_q [8];
    for (int i = 1; i <= 8; i++) bus_write(2'd0, 32'(i));
    bus_read(2'd1, rd);
    n_checks++;
    if (rd !== 32'h802) begin
      n_fail++; $display("FAIL pp_full: got %h expected 00000802", rd);
    end
    @(negedge clk);
    address = 2'd0; writedata = 32'hA; chipselect = 1'b1; write_n = 1'b0; key_ready = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; key_ready = 1'b0;
    bus_read(2'd1, rd);
    n_checks++;
    if (rd !== 32'h802) begin
      n_fail++; $display("FAIL pp_status: got %h expected 00000802", rd);
    end
    for (int i = 0; i < 7; i++) exp_q[i] = 32'(i + 2);
    exp_q[7] = 32'hA;
    for (int i = 0; i < 8; i++) begin
      pop_one(v, d);
      n_checks++;
      if (v !== 1'b1 || d !== exp_q[i]) begin
        n_fail++; $display("FAIL pp_drain[%0d]: valid=%b data=%h expected 1 %h", i, v, d, exp_q[i]);
      end
    end
  endtask

  task automatic test_irq;
    logic [31:0] rd;
    bus_write(2'd2, 32'h5);
    for (int i = 1; i <= 9; i++) bus_write(2'd0, 32'(i + 16));
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_set: got %b expected 1", irq);
    end
    bus_write(2'd1, 32'h4);
    @(negedge clk);
    bus_read(2'd1, rd);
    n_checks++;
    if (irq !== 1'b0 || rd[2] !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear: irq=%b ovf=%b expected 0 0", irq, rd[2]);
    end
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'h5) begin
      n_fail++; $display("FAIL irq_ctrl_read: got %h expected 00000005", rd);
    end
  endtask

  task automatic test_flush;
    logic [31:0] rd;
    bus_write(2'd2, 32'h3);
    bus_write(2'd0, 32'h11);
    bus_write(2'd0, 32'h22);
    bus_write(2'd0, 32'h33);
    bus_read(2'd1, rd);
    n_checks++;
    if (rd !== 32'h300) begin
      n_fail++; $display("FAIL flush_pre: got %h expected 00000300", rd);
    end
    bus_write(2'd2, 32'h3);
    bus_read(2'd1, rd);
    n_checks++;
    if (key_valid !== 1'b0 || rd !== 32'h1 || out_port !== 32'h33) begin
      n_fail++; $display("FAIL flush: valid=%b status=%h out_port=%h expected 0 1 33", key_valid, rd, out_port);
    end
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++; $display("FAIL flush_ctrl_read: got %h expected 00000001", rd);
    end
  endtask

  task automatic test_enable;
    logic [31:0] rd;
    bus_write(2'd2, 32'h0);
    bus_write(2'd0, 32'h55);
    bus_read(2'd1, rd);
    n_checks++;
    if (out_port !== 32'h55 || key_valid !== 1'b0 || rd !== 32'h1) begin
      n_fail++; $display("FAIL disabled_write: out_port=%h valid=%b status=%h expected 55 0 1", out_port, key_valid, rd);
    end
    bus_read(2'd0, rd);
    n_checks++;
    if (rd !== 32'h55) begin
      n_fail++; $display("FAIL data_read: got %h expected 00000055", rd);
    end
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL reserved_read: got %h expected 0", rd);
    end
  endtask

  task automatic test_async_reset;
    bus_write(2'd2, 32'h1);
    bus_write(2'd0, 32'h77);
    bus_write(2'd0, 32'h78);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (key_valid !== 1'b0 || key_data !== 32'h0 || out_port !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: valid=%b data=%h out_port=%h expected 0 0 0", key_valid, key_data, out_port);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_empty: key_valid=%b expected 0", key_valid);
    end
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; key_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_full_pushpop();
    test_irq();
    test_flush();
    test_enable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
